mem_c_collect: RTL and testbench
================================

MEM_C_COLLECT -- requirements
Module: mem_c_collect

Interface
REQ-001 Parameter BITS_C, default 24: signed width of one result element.
REQ-002 Parameter DEPTH, default 8: matrix dimension and number of result lanes; power of two, at least 2.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle pulse that begins a capture of one DEPTH x DEPTH result.
REQ-006 en  input  1  capture advance enable; when 0, capture stalls with state and counter held.
REQ-007 Cin  input  DEPTH x BITS_C signed  skewed result lanes from the systolic array.
REQ-008 rd_en  input  1  read request.
REQ-009 row, col  input  $clog2(DEPTH) each  read address.
REQ-010 Cout  output  BITS_C signed  read data.
REQ-011 rd_valid  output  1  Cout holds valid data for the read issued on the previous cycle.
REQ-012 busy  output  1  capture in progress.
REQ-013 done  output  1  a complete matrix is stored; held until the next start or reset.

Function
REQ-014 The FSM SHALL have three states: IDLE, CAPTURE and DONE.
REQ-015 IDLE -> CAPTURE on start; CAPTURE -> DONE when tick counter t = 2*DEPTH-2 and en=1; DONE -> CAPTURE on start.
REQ-016 start while in CAPTURE SHALL be ignored.
REQ-017 On entry to CAPTURE, t SHALL be 0; t SHALL increment by 1 each cycle that en=1 and SHALL not wrap.
REQ-018 In CAPTURE with en=1, for each lane k with 0 <= t-k < DEPTH, the block SHALL store Cin[k] into C[t-k][k] (deskew).
REQ-019 Lanes outside that window SHALL not write storage.
REQ-020 The first Cin sample, lane 0 element C[0][0], SHALL be taken on the first en=1 cycle after the start cycle; Cin is ignored on the start cycle itself.
REQ-021 busy SHALL be 1 exactly in CAPTURE; done SHALL be 1 exactly in DONE.
REQ-022 Reads SHALL have a latency of 1: rd_en=1 on cycle n gives Cout=C[row][col] and rd_valid=1 on cycle n+1.
REQ-023 A read issued while busy=1 SHALL return Cout=0 with rd_valid=0.
REQ-024 With no read, Cout SHALL hold its last value and rd_valid SHALL be 0.
REQ-025 Back-to-back reads SHALL be accepted every cycle.
REQ-026 Storage is not cleared on start; every element is overwritten during CAPTURE.

Reset
REQ-027 rst=1 SHALL force IDLE, t=0, busy=0, done=0, rd_valid=0 and Cout=0, and SHALL zero all DEPTH*DEPTH elements.
REQ-028 Reset during CAPTURE SHALL abandon the capture; reads of a partial result SHALL return 0.
REQ-029 rst SHALL take priority over start, en and rd_en.

Structure
REQ-030 The FSM state enum and default BITS_C/DEPTH constants SHALL live in the shared matmul package.
REQ-031 One sub-module, mem_c_lane, SHALL hold one column's DEPTH-entry store with its write-window decode; it is instantiated DEPTH times.

Verification
REQ-032 Reset then read all 64 addresses -> every Cout = 0, rd_valid = 1 one cycle after each rd_en.
REQ-033 start, drive skewed lanes so C[i][j] = i*8+j, en=1 for 15 cycles -> done=1 after tick 14; reading row=3,col=5 gives 29.
REQ-034 Same stream with en=0 on ticks 4 and 9 -> identical stored matrix, done asserted 2 cycles later than in REQ-033.
REQ-035 rd_en during CAPTURE -> rd_valid=0, Cout=0; a second start at t=5 is ignored and the capture completes normally.
REQ-036 rst at t=7, then read row=0,col=0 -> 0 with busy=0 and done=0.
REQ-037 Negative values: C[7][7] = -8388608 captured -> Cout=-8388608, with correct sign extension in the bench compare.

Source files
------------

// File: rtl/mem_c_collect_pkg.sv
// Shared matmul definitions: result-collector FSM states and default sizing.
package mem_c_collect_pkg;

    localparam int BITS_C_DEFAULT = 24;
    localparam int DEPTH_DEFAULT  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } collect_state_e;

endpackage

// File: rtl/mem_c_lane.sv
// One result column: DEPTH-entry store that writes only while the tick counter
// is inside this lane's deskew window (LANE <= t < LANE+DEPTH).
module mem_c_lane
    import mem_c_collect_pkg::*;
#(
    parameter int BITS_C = BITS_C_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int LANE   = 0,
    localparam int AW    = $clog2(DEPTH),
    localparam int TW    = $clog2(2*DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [TW-1:0]     t,
    input  logic [BITS_C-1:0] din,
    input  logic [AW-1:0]     rd_row,
    output logic [BITS_C-1:0] rd_data
);

    logic [BITS_C-1:0] mem [DEPTH];
    logic [TW:0]       diff;
    logic              in_window;
    logic [AW-1:0]     wr_row;

    // An extra borrow bit makes t < LANE show up as a negative difference.
    always_comb begin
        diff      = {1'b0, t} - (TW+1)'(LANE);
        in_window = !diff[TW] && (diff[TW-1:0] < TW'(DEPTH));
        wr_row    = diff[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && in_window) begin
            mem[wr_row] <= din;
        end
    end

    assign rd_data = mem[rd_row];

endmodule

// File: rtl/mem_c_collect.sv
// Collects the skewed result stream of a DEPTH x DEPTH systolic array into a
// deskewed matrix store and serves 1-cycle-latency random reads once complete.
module mem_c_collect
    import mem_c_collect_pkg::*;
#(
    parameter int BITS_C = BITS_C_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int TW    = $clog2(2*DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 en,
    input  logic signed [DEPTH-1:0][BITS_C-1:0]  Cin,
    input  logic                                 rd_en,
    input  logic [AW-1:0]                        row,
    input  logic [AW-1:0]                        col,
    output logic signed [BITS_C-1:0]             Cout,
    output logic                                 rd_valid,
    output logic                                 busy,
    output logic                                 done
);

    localparam logic [TW-1:0] LAST_TICK = TW'(2*DEPTH-2);

    collect_state_e    state, state_nxt;
    logic [TW-1:0]     t, t_nxt;
    logic              capture_we;
    logic [BITS_C-1:0] lane_rd [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
        end
    end

    // The tick counter only moves on enabled capture cycles and stops at the last tick.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                    t_nxt     = '0;
                end
            end
            CAPTURE: begin
                if (en) begin
                    if (t == LAST_TICK) begin
                        state_nxt = DONE;
                    end else begin
                        t_nxt = t + 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                    t_nxt     = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                t_nxt     = '0;
            end
        endcase
    end

    assign busy       = (state == CAPTURE);
    assign done       = (state == DONE);
    assign capture_we = busy && en;

    for (genvar k = 0; k < DEPTH; k++) begin : g_lane
        mem_c_lane #(
            .BITS_C (BITS_C),
            .DEPTH  (DEPTH),
            .LANE   (k)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we      (capture_we),
            .t       (t),
            .din     (Cin[k]),
            .rd_row  (row),
            .rd_data (lane_rd[k])
        );
    end

    // Reads during a capture are refused and return zero rather than a partial matrix.
    always_ff @(posedge clk) begin
        if (rst) begin
            Cout     <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            if (busy) begin
                Cout     <= '0;
                rd_valid <= 1'b0;
            end else begin
                Cout     <= $signed(lane_rd[col]);
                rd_valid <= 1'b1;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_c_collect.sv
// Directed self-checking bench for mem_c_collect (DEPTH=8, BITS_C=24).
module tb_mem_c_collect;

    localparam int BITS_C = 24;
    localparam int DEPTH  = 8;
    localparam logic [BITS_C-1:0] JUNK = 24'hA5A5A5;

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                start;
    logic                                en;
    logic signed [DEPTH-1:0][BITS_C-1:0] Cin;
    logic                                rd_en;
    logic [2:0]                          row;
    logic [2:0]                          col;
    logic signed [BITS_C-1:0]            Cout;
    logic                                rd_valid;
    logic                                busy;
    logic                                done;

    int tests  = 0;
    int failed = 0;
    int srcMat [DEPTH][DEPTH];
    int expMat [DEPTH][DEPTH];

    mem_c_collect #(.BITS_C(BITS_C), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .Cin      (Cin),
        .rd_en    (rd_en),
        .row      (row),
        .col      (col),
        .Cout     (Cout),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [47:0] obs,
                               input logic signed [47:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic driveTick(input int tick);
        for (int k = 0; k < DEPTH; k++) begin
            if (tick - k >= 0 && tick - k < DEPTH) begin
                Cin[k] = BITS_C'(srcMat[tick-k][k]);
            end else begin
                Cin[k] = JUNK;
            end
        end
    endtask

    task automatic readOne(input int r, input int c, input int exp, input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        row   = 3'(r);
        col   = 3'(c);
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput({tag, "_valid"}, rd_valid, 1);
        checkOutput(tag, Cout, exp);
    endtask

    // Back-to-back reads of every address, then a no-read cycle to check hold.
    task automatic readAll(input string tag);
        for (int a = 0; a <= DEPTH*DEPTH; a++) begin
            @(negedge clk);
            if (a > 0) begin
                checkOutput($sformatf("%s_v%0d", tag, a-1), rd_valid, 1);
                checkOutput($sformatf("%s_c%0d", tag, a-1), Cout,
                            expMat[(a-1)/DEPTH][(a-1)%DEPTH]);
            end
            if (a < DEPTH*DEPTH) begin
                rd_en = 1'b1;
                row   = 3'(a / DEPTH);
                col   = 3'(a % DEPTH);
            end else begin
                rd_en = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput({tag, "_idle_valid"}, rd_valid, 0);
        checkOutput({tag, "_hold"}, Cout, expMat[DEPTH-1][DEPTH-1]);
    endtask

    // One capture run; negative arguments disable the optional events.
    task automatic applyStimulus(input int stallA, input int stallB, input int restartTick,
                                 input int readTick, input int abortTick, input string tag);
        @(negedge clk);
        start = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < DEPTH; k++) Cin[k] = JUNK;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy"}, busy, 1);
        for (int tick = 0; tick < 2*DEPTH-1; tick++) begin
            if (tick == stallA || tick == stallB) begin
                en = 1'b0;
                for (int k = 0; k < DEPTH; k++) Cin[k] = JUNK;
                @(negedge clk);
                checkOutput($sformatf("%s_stall%0d_busy", tag, tick), busy, 1);
            end
            driveTick(tick);
            en    = 1'b1;
            start = (tick == restartTick);
            if (tick == readTick) begin
                rd_en = 1'b1;
                row   = 3'd0;
                col   = 3'd0;
            end
            if (tick == abortTick) rst = 1'b1;
            @(negedge clk);
            start = 1'b0;
            rd_en = 1'b0;
            if (tick == readTick) begin
                checkOutput({tag, "_busyread_valid"}, rd_valid, 0);
                checkOutput({tag, "_busyread_data"}, Cout, 0);
            end
            if (tick == abortTick) begin
                rst = 1'b0;
                en  = 1'b0;
                checkOutput({tag, "_abort_busy"}, busy, 0);
                checkOutput({tag, "_abort_done"}, done, 0);
                return;
            end
            if (tick == 2*DEPTH-3) checkOutput({tag, "_done_early"}, done, 0);
        end
        en = 1'b0;
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        rd_en = 1'b0;
        row   = '0;
        col   = '0;
        for (int k = 0; k < DEPTH; k++) Cin[k] = JUNK;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", rd_valid, 0);
        checkOutput("rst_cout", Cout, 0);
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++) expMat[i][j] = 0;
        readAll("rst");

        // Plain capture of C[i][j] = i*8+j.
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++) srcMat[i][j] = i*8 + j;
        applyStimulus(-1, -1, -1, -1, -1, "cap");
        expMat = srcMat;
        readOne(3, 5, 29, "c35");
        readAll("cap");

        // Negative data, including the most negative 24-bit value.
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++) srcMat[i][j] = (i*8 + j)*1000 - 30000;
        srcMat[7][7] = -8388608;
        applyStimulus(-1, -1, -1, -1, -1, "neg");
        expMat = srcMat;
        readOne(7, 7, -8388608, "neg77");
        readAll("neg");

        // Same i*8+j stream with stalls before ticks 4 and 9; overwrites the negative data.
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++) srcMat[i][j] = i*8 + j;
        applyStimulus(4, 9, -1, -1, -1, "stall");
        expMat = srcMat;
        readAll("stall");

        // Read during capture and a second start at t=5.
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++) srcMat[i][j] = (i*8 + j)*3 - 50;
        applyStimulus(-1, -1, 5, 3, -1, "rstart");
        expMat = srcMat;
        readAll("rstart");

        // Reset at t=7 abandons the capture and clears storage.
        applyStimulus(-1, -1, -1, -1, 7, "abort");
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++) expMat[i][j] = 0;
        readOne(0, 0, 0, "abort00");
        checkOutput("abort_busy_after", busy, 0);
        checkOutput("abort_done_after", done, 0);
        readAll("abort");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
